// File: rtl/instruction_decoder.sv
// Instruction register and decoder for the 8-bit nanoprocessor: turns the fetched
// word into register/ALU enables, bus source select and sequencer jump requests.
module instruction_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pm_data,
    input  logic       alu_zero,
    output logic [7:0] ir,
    output logic       jmp,
    output logic       jmp_nz,
    output logic [3:0] jmp_addr,
    output logic       dont_jmp,
    output logic [7:0] reg_en,
    output logic       alu_en,
    output logic [3:0] source_sel,
    output logic [3:0] alu_func,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_MOVE,
        CLS_ALU,
        CLS_RSVD,
        CLS_JMP,
        CLS_JNZ
    } instr_class_e;

    localparam logic [3:0] SEL_R    = 4'd8;
    localparam logic [3:0] SEL_IMM  = 4'd9;
    localparam logic [3:0] SEL_IDLE = 4'd15;

    logic         ir_valid;
    logic         z;
    instr_class_e cls;
    logic [2:0]   mv_dst;
    logic [2:0]   mv_src;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir          <= 8'h00;
            ir_valid    <= 1'b0;
            z           <= 1'b0;
            instr_count <= 8'h00;
        end else begin
            ir       <= pm_data;
            ir_valid <= 1'b1;
            if (ir_valid && cls == CLS_ALU)
                z <= alu_zero;
            if (ir_valid)
                instr_count <= instr_count + 8'd1;
        end
    end

    assign dont_jmp = z;
    assign mv_dst   = ir[5:3];
    assign mv_src   = ir[2:0];

    always_comb begin
        cls = CLS_RSVD;
        if (!ir[7])
            cls = CLS_LOAD;
        else if (!ir[6])
            cls = CLS_MOVE;
        else
            case (ir[5:4])
                2'b00:   cls = CLS_ALU;
                2'b01:   cls = CLS_RSVD;
                2'b10:   cls = CLS_JMP;
                default: cls = CLS_JNZ;
            endcase
    end

    // NOTE: every output gets its inactive value first, so no path can infer a latch.
    always_comb begin
        reg_en     = 8'h00;
        alu_en     = 1'b0;
        source_sel = SEL_IDLE;
        alu_func   = 4'h0;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        jmp_addr   = 4'h0;
        if (ir_valid) begin
            case (cls)
                CLS_LOAD: begin
                    reg_en     = 8'h01 << ir[6:4];
                    source_sel = SEL_IMM;
                end
                CLS_MOVE: begin
                    // Self-move is a NOP, except slot 4 where the source reads r, not o_reg.
                    if (mv_dst != mv_src || mv_dst == 3'd4) begin
                        reg_en     = 8'h01 << mv_dst;
                        source_sel = (mv_src == 3'd4) ? SEL_R : {1'b0, mv_src};
                    end
                end
                CLS_ALU: begin
                    alu_en   = 1'b1;
                    alu_func = ir[3:0];
                end
                CLS_JMP: begin
                    jmp      = 1'b1;
                    jmp_addr = ir[3:0];
                end
                CLS_JNZ: begin
                    jmp_nz   = 1'b1;
                    jmp_addr = ir[3:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed self-checking bench for instruction_decoder.
module tb_instruction_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic [7:0] ir;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic       alu_en;
    logic [3:0] source_sel;
    logic [3:0] alu_func;
    logic [7:0] instr_count;

    int passed = 0;
    int total  = 0;

    instruction_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .pm_data     (pm_data),
        .alu_zero    (alu_zero),
        .ir          (ir),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .jmp_addr    (jmp_addr),
        .dont_jmp    (dont_jmp),
        .reg_en      (reg_en),
        .alu_en      (alu_en),
        .source_sel  (source_sel),
        .alu_func    (alu_func),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // az is the ALU zero result for the instruction in ir up to this edge.
    task automatic step(input logic [7:0] pm, input logic az);
        pm_data  = pm;
        alu_zero = az;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        pm_data  = 8'h00;
        alu_zero = 1'b0;
        #12;
        total++;
        if (ir !== 8'h00 || dont_jmp !== 1'b0 || instr_count !== 8'h00 ||
            reg_en !== 8'h00 || source_sel !== 4'd15)
            $display("FAIL reset_state: ir=%h z=%b cnt=%0d reg_en=%h sel=%0d, expected 00 0 0 00 15",
                     ir, dont_jmp, instr_count, reg_en, source_sel);
        else passed++;
        #10 reset = 1'b0;
        step(8'h00, 1'b0);
        total++;
        if (reg_en !== 8'h01 || source_sel !== 4'd9 || instr_count !== 8'h00)
            $display("FAIL first_decode: reg_en=%h sel=%0d cnt=%0d, expected 01 9 0",
                     reg_en, source_sel, instr_count);
        else passed++;
    endtask

    task automatic test_load_move;
        step(8'h5A, 1'b0);
        total++;
        if (ir !== 8'h5A || reg_en !== 8'h20 || source_sel !== 4'd9 || instr_count !== 8'd1)
            $display("FAIL load_5a: ir=%h reg_en=%h sel=%0d cnt=%0d, expected 5a 20 9 1",
                     ir, reg_en, source_sel, instr_count);
        else passed++;
        step(8'h8C, 1'b0);
        total++;
        if (reg_en !== 8'h02 || source_sel !== 4'd8)
            $display("FAIL move_8c: reg_en=%h sel=%0d, expected 02 8", reg_en, source_sel);
        else passed++;
        step(8'h89, 1'b0);
        total++;
        if (reg_en !== 8'h00 || source_sel !== 4'd15 || alu_en !== 1'b0)
            $display("FAIL move_nop_89: reg_en=%h sel=%0d alu_en=%b, expected 00 15 0",
                     reg_en, source_sel, alu_en);
        else passed++;
        step(8'hA4, 1'b0);
        total++;
        if (reg_en !== 8'h10 || source_sel !== 4'd8)
            $display("FAIL move_a4: reg_en=%h sel=%0d, expected 10 8", reg_en, source_sel);
        else passed++;
        step(8'hB3, 1'b0);
        total++;
        if (reg_en !== 8'h40 || source_sel !== 4'd3)
            $display("FAIL move_b3: reg_en=%h sel=%0d, expected 40 3", reg_en, source_sel);
        else passed++;
    endtask

    task automatic test_alu_jnz;
        step(8'hC3, 1'b0);
        total++;
        if (alu_en !== 1'b1 || alu_func !== 4'd3 || source_sel !== 4'd15 || reg_en !== 8'h00)
            $display("FAIL alu_c3: alu_en=%b func=%0d sel=%0d reg_en=%h, expected 1 3 15 00",
                     alu_en, alu_func, source_sel, reg_en);
        else passed++;
        step(8'hF7, 1'b1);
        total++;
        if (jmp_nz !== 1'b1 || jmp_addr !== 4'd7 || dont_jmp !== 1'b1 || jmp !== 1'b0 || alu_en !== 1'b0)
            $display("FAIL jnz_z1: jnz=%b addr=%0d dont_jmp=%b jmp=%b alu_en=%b, expected 1 7 1 0 0",
                     jmp_nz, jmp_addr, dont_jmp, jmp, alu_en);
        else passed++;
        step(8'hC3, 1'b1);
        step(8'hF7, 1'b0);
        total++;
        if (jmp_nz !== 1'b1 || jmp_addr !== 4'd7 || dont_jmp !== 1'b0)
            $display("FAIL jnz_z0: jnz=%b addr=%0d dont_jmp=%b, expected 1 7 0",
                     jmp_nz, jmp_addr, dont_jmp);
        else passed++;
    endtask

    task automatic test_flag_hold;
        step(8'hC5, 1'b0);
        step(8'h11, 1'b1);
        total++;
        if (dont_jmp !== 1'b1)
            $display("FAIL flag_set: dont_jmp=%b, expected 1", dont_jmp);
        else passed++;
        step(8'h22, 1'b0);
        step(8'h33, 1'b1);
        step(8'h44, 1'b0);
        total++;
        if (dont_jmp !== 1'b1 || reg_en !== 8'h10)
            $display("FAIL flag_hold: dont_jmp=%b reg_en=%h, expected 1 10", dont_jmp, reg_en);
        else passed++;
    endtask

    task automatic test_jump;
        step(8'hE9, 1'b0);
        total++;
        if (jmp !== 1'b1 || jmp_addr !== 4'd9 || jmp_nz !== 1'b0 || reg_en !== 8'h00)
            $display("FAIL jmp_e9: jmp=%b addr=%0d jnz=%b reg_en=%h, expected 1 9 0 00",
                     jmp, jmp_addr, jmp_nz, reg_en);
        else passed++;
        step(8'hD5, 1'b0);
        total++;
        if ({reg_en, alu_en, source_sel, alu_func, jmp, jmp_nz, jmp_addr} !==
            {8'h00, 1'b0, 4'd15, 4'd0, 1'b0, 1'b0, 4'd0})
            $display("FAIL reserved_d5: reg_en=%h alu_en=%b sel=%0d func=%0d jmp=%b jnz=%b addr=%0d, expected inactive",
                     reg_en, alu_en, source_sel, alu_func, jmp, jmp_nz, jmp_addr);
        else passed++;
    endtask

    task automatic test_reset_mid;
        #2 reset = 1'b1;
        #1;
        total++;
        if (ir !== 8'h00 || dont_jmp !== 1'b0 || instr_count !== 8'h00 ||
            reg_en !== 8'h00 || source_sel !== 4'd15)
            $display("FAIL reset_mid: ir=%h z=%b cnt=%0d reg_en=%h sel=%0d, expected 00 0 0 00 15",
                     ir, dont_jmp, instr_count, reg_en, source_sel);
        else passed++;
        #1 reset = 1'b0;
        step(8'h37, 1'b0);
        total++;
        if (reg_en !== 8'h08 || source_sel !== 4'd9 || ir !== 8'h37)
            $display("FAIL reset_release: reg_en=%h sel=%0d ir=%h, expected 08 9 37",
                     reg_en, source_sel, ir);
        else passed++;
    endtask

    task automatic test_counter;
        #3 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 11; i++) step(8'h00, 1'b0);
        total++;
        if (instr_count !== 8'd10)
            $display("FAIL count_10: cnt=%0d, expected 10", instr_count);
        else passed++;
        #3 reset = 1'b1;
        #1;
        total++;
        if (instr_count !== 8'd0)
            $display("FAIL count_async_clear: cnt=%0d, expected 0", instr_count);
        else passed++;
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) step(8'h00, 1'b0);
        total++;
        if (instr_count !== 8'd255)
            $display("FAIL count_255: cnt=%0d, expected 255", instr_count);
        else passed++;
        step(8'h00, 1'b0);
        total++;
        if (instr_count !== 8'd0)
            $display("FAIL count_wrap: cnt=%0d, expected 0", instr_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_move();
        test_alu_jnz();
        test_flag_hold();
        test_jump();
        test_reset_mid();
        test_counter();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Instruction decoder for the 8-bit nanoprocessor: registers the instruction word fetched from program memory and decodes it into register load enables, data-path select, ALU function, and the jump controls consumed by the program sequencer (jmp, jmp_nz, jmp_addr, dont_jmp). It owns the zero flag, the instruction-valid flag, and a retired-instruction counter. It sits between program-memory data out and the sequencer/data path, closing the fetch–decode loop.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- pm_data  in  8  instruction word from program memory at address pm_addr
- alu_zero  in  1  ALU result is zero for the instruction currently in ir
- ir  out  8  registered instruction word
- jmp  out  1  unconditional jump request
- jmp_nz  out  1  conditional jump-if-not-zero request
- jmp_addr  out  4  jump target nibble (sequencer forms {jmp_addr,4'h0})
- dont_jmp  out  1  registered zero flag z; suppresses jmp_nz when 1
- reg_en  out  8  one-hot load enable for x0,x1,y0,y1,o_reg,m,i,dm (bits 0..7)
- alu_en  out  1  load enable for ALU result register r
- source_sel  out  4  data-bus source: 0–7 register file, 8 = r, 9 = immediate ir[3:0], 15 = idle
- alu_func  out  4  ALU function code
- instr_count  out  8  number of valid instructions decoded since reset

## Operation
- Every rising edge: ir <= pm_data; ir_valid <= 1. Reset: ir = 8'h00, ir_valid = 0, z = 0, instr_count = 0.
- All decode outputs are combinational from ir and are forced to inactive when ir_valid = 0 (the first cycle after reset). Inactive = all enables 0, jmp = jmp_nz = 0, source_sel = 15, alu_func = 0, jmp_addr = 0.
- Formats (ir_valid = 1):
  - 0ddd_nnnn load: reg_en[ddd] = 1, source_sel = 9.
  - 10dd_dsss move: reg_en[ddd] = 1; source_sel = 8 if sss = 4 (r replaces write-only o_reg), else {0,sss}. ddd = sss → NOP (no enable, source_sel = 15), except ddd = sss = 4 (move r to o_reg), which is legal.
  - 1100_ffff ALU: alu_en = 1, alu_func = ffff, source_sel = 15.
  - 1101_xxxx reserved: NOP.
  - 1110_aaaa jmp: jmp = 1, jmp_addr = aaaa.
  - 1111_aaaa jnz: jmp_nz = 1, jmp_addr = aaaa.
- jmp_addr = ir[3:0] for jmp/jnz only, otherwise 0.
- Zero flag: z <= alu_zero at the edge ending a valid ALU instruction; holds otherwise. dont_jmp = z at all times (not gated by ir_valid).
- instr_count increments by 1 per edge where ir_valid = 1 (including NOPs); wraps 255 → 0.

## Timing
- Fetch-to-decode latency: 1 clock (pm_data sampled at edge N, decode valid after edge N).
- ALU then jnz back-to-back: z updated at the edge between them, so the jnz sees the new flag. No bubble.
- Taken jump: the sequencer redirects pm_addr combinationally in the same cycle, so the next ir is the target. No flush or stall in this block.
- Reset asserted mid-program: all state clears immediately (asynchronously), and outputs go inactive without waiting for clk. On the first edge after deassertion, ir loads pm_data and ir_valid becomes 1. Decode is active from then on.
- Flag/decode hazard: alu_zero is sampled only for ALU instructions. Glitches on other cycles have no effect.

## Test plan
- Reset: assert reset between edges → ir = 00, z = 0, instr_count = 0, reg_en = 0, source_sel = 15 without a clock edge. First edge after release with pm_data = 8'h00 → reg_en = 8'h01, source_sel = 9.
- Load/move sweep: pm_data = 8'h5A → reg_en = 8'h20, source_sel = 9. Then 8'h8C (dst 1, src 4) → reg_en = 8'h02, source_sel = 8. Then 8'h89 (dst 1 = src 1) → NOP. Then 8'hA4 (dst 4 = src 4) → reg_en = 8'h10, source_sel = 8.
- ALU then jnz: 8'hC3 with alu_zero = 1, then 8'hF7 → alu_func = 3, alu_en = 1; next cycle jmp_nz = 1, jmp_addr = 7, dont_jmp = 1. Repeat with alu_zero = 0 → dont_jmp = 0.
- Flag hold: ALU with alu_zero = 1, then three loads with alu_zero toggling → dont_jmp stays 1.
- Jump: 8'hE9 → jmp = 1, jmp_addr = 9, jmp_nz = 0, reg_en = 0. Then 8'hD5 → all controls inactive.
- Counter wrap: 256 valid edges after reset → instr_count returns to 0. Reset after 10 edges → 0 immediately.
